// File: rtl/xalu_ise_pkg.sv
// Shared definitions for the core-side ISE issue path: custom opcode slots,
// funct field widths and the issuer FSM state encoding.
package xalu_ise_pkg;

  localparam int ISE_FN_W  = 5;
  localparam int ISE_IMM_W = 7;

  localparam logic [1:0] CUSTOM_0 = 2'd0;
  localparam logic [1:0] CUSTOM_1 = 2'd1;
  localparam logic [1:0] CUSTOM_2 = 2'd2;
  localparam logic [1:0] CUSTOM_3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ise_state_e;

endpackage

// File: rtl/xalu_ise_issue.sv
// Requester end of the ISE port: holds an op on ise_* until a unit claims it
// (or a bounded wait expires), then presents the result to writeback.
module xalu_ise_issue
  import xalu_ise_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  int TIMEOUT = 8,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                 ise_clk,
  input  logic                 ise_rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ISE_FN_W-1:0]  req_fn,
  input  logic [ISE_IMM_W-1:0] req_imm,
  input  logic [XLEN-1:0]      req_rs1,
  input  logic [XLEN-1:0]      req_rs2,
  input  logic [4:0]           req_rd,
  output logic [ISE_FN_W-1:0]  ise_fn,
  output logic [ISE_IMM_W-1:0] ise_imm,
  output logic [XLEN-1:0]      ise_in1,
  output logic [XLEN-1:0]      ise_in2,
  output logic                 ise_val,
  input  logic                 ise_oval,
  input  logic [XLEN-1:0]      ise_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_illegal
);

  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  ise_state_e    state;
  logic [CW-1:0] wait_cnt;

  assign req_ready = (state == IDLE) && !ise_rst && !flush;

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of state and wait_cnt, regardless of statement order.
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ise_fn      <= '0;
      ise_imm     <= '0;
      ise_in1     <= '0;
      ise_in2     <= '0;
      ise_val     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      rsp_illegal <= 1'b0;
    end else if (flush) begin
      // Abandon the op outright; a same-cycle oval is dropped with it.
      state     <= IDLE;
      wait_cnt  <= '0;
      ise_val   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ise_fn   <= req_fn;
            ise_imm  <= req_imm;
            ise_in1  <= req_rs1;
            ise_in2  <= req_rs2;
            rsp_rd   <= req_rd;
            ise_val  <= 1'b1;
            wait_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (ise_oval) begin
            rsp_data    <= ise_out;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
            ise_val     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            rsp_data    <= '0;
            rsp_illegal <= 1'b1;
            rsp_valid   <= 1'b1;
            ise_val     <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            state    <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Directed bench for xalu_ise_issue with combinational, multi-cycle and
// silent ISE stubs; expected values are hand-computed constants.
module tb_xalu_ise_issue;

  localparam int XLEN = 64;

  logic            clk;
  logic            ise_rst;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_fn;
  logic [6:0]      req_imm;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd;
  logic [4:0]      ise_fn;
  logic [6:0]      ise_imm;
  logic [XLEN-1:0] ise_in1;
  logic [XLEN-1:0] ise_in2;
  logic            ise_val;
  logic            ise_oval;
  logic [XLEN-1:0] ise_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_rd;
  logic            rsp_illegal;

  int vectors    = 0;
  int miscompares = 0;

  // Stub modes: 0 silent, 1 combinational, 2 answers 3 cycles after ise_val rises
  int         stub_mode  = 0;
  logic       force_oval = 1'b0;
  logic [3:0] val_cnt;

  xalu_ise_issue dut (
    .ise_clk    (clk),
    .ise_rst    (ise_rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fn     (req_fn),
    .req_imm    (req_imm),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .ise_fn     (ise_fn),
    .ise_imm    (ise_imm),
    .ise_in1    (ise_in1),
    .ise_in2    (ise_in2),
    .ise_val    (ise_val),
    .ise_oval   (ise_oval),
    .ise_out    (ise_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ise_val) val_cnt <= '0;
    else          val_cnt <= val_cnt + 4'd1;
  end

  always_comb begin
    ise_oval = force_oval;
    ise_out  = 64'hDEAD_BEEF_0BAD_F00D;
    case (stub_mode)
      1: begin
        ise_oval = force_oval | (ise_val && ise_fn[1:0] == 2'b01 && ise_imm[6:5] == 2'b10);
        ise_out  = (ise_in1 << 4) + ise_in2;
      end
      2: begin
        ise_oval = force_oval | (ise_val && val_cnt == 4'd3);
        ise_out  = ise_in1 ^ ise_in2;
      end
      default: ;
    endcase
  end

  // Presents one op, passes the accept edge and returns at the first sample after it.
  task automatic issue(input logic [4:0] fn, input logic [6:0] imm,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [4:0] rd);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
    end
    req_fn = fn; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    ise_rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_fn = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ise_fn, ise_imm, ise_in1, ise_in2, ise_val, rsp_valid, rsp_data, rsp_rd, rsp_illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ise_val=%b rsp_valid=%b rsp_data=%h expected all zero",
               ise_val, rsp_valid, rsp_data);
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b expected 0 during reset", req_ready);
    end
    ise_rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: req_ready=%b expected 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_comb_ise;
    int lat;
    stub_mode = 1;
    issue(5'h01, 7'h40, 64'h1, 64'h2, 5'd5);
    vectors++;
    if (ise_val !== 1'b1 || ise_fn !== 5'h01 || ise_imm !== 7'h40 || ise_in1 !== 64'h1 || ise_in2 !== 64'h2) begin
      miscompares++;
      $display("FAIL comb_drive: val=%b fn=%h imm=%h in1=%h in2=%h expected 1/01/40/1/2",
               ise_val, ise_fn, ise_imm, ise_in1, ise_in2);
    end
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL comb_latency: got %0d expected 2", lat);
    end
    vectors++;
    if (rsp_data !== 64'h12 || rsp_rd !== 5'd5 || rsp_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL comb_result: data=%h rd=%0d illegal=%b expected 12/5/0", rsp_data, rsp_rd, rsp_illegal);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL comb_retire: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_timeout;
    int lat;
    int val_cycles;
    stub_mode = 0;
    issue(5'h00, 7'h00, 64'h55, 64'hAA, 5'd7);
    lat = 1; val_cycles = 0;
    while (!rsp_valid && lat < 40) begin
      if (ise_val) val_cycles++;
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (val_cycles !== 8) begin
      miscompares++;
      $display("FAIL timeout_val_cycles: got %0d expected 8", val_cycles);
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d expected 9", lat);
    end
    vectors++;
    if (rsp_illegal !== 1'b1 || rsp_data !== 64'h0 || rsp_rd !== 5'd7 || ise_val !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_result: illegal=%b data=%h rd=%0d ise_val=%b expected 1/0/7/0",
               rsp_illegal, rsp_data, rsp_rd, ise_val);
    end
    @(negedge clk);
  endtask

  task automatic test_multi_cycle;
    int lat;
    int pulse_hits;
    stub_mode = 2;
    issue(5'h02, 7'h11, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 5'd12);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      vectors++;
      if (ise_val !== 1'b1 || ise_fn !== 5'h02 || ise_imm !== 7'h11 ||
          ise_in1 !== 64'h0123_4567_89AB_CDEF || ise_in2 !== 64'hFFFF_0000_FFFF_0000) begin
        miscompares++;
        $display("FAIL multi_hold: cycle %0d val=%b fn=%h imm=%h in1=%h in2=%h not held",
                 lat, ise_val, ise_fn, ise_imm, ise_in1, ise_in2);
      end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("FAIL multi_latency: got %0d expected 5", lat);
    end
    vectors++;
    if (rsp_data !== 64'hFEDC_4567_7654_CDEF || rsp_rd !== 5'd12 || rsp_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_result: data=%h rd=%0d illegal=%b expected FEDC45677654CDEF/12/0",
               rsp_data, rsp_rd, rsp_illegal);
    end
    @(negedge clk);
    stub_mode = 0;
    force_oval = 1'b1;
    pulse_hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) force_oval = 1'b0;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ise_val !== 1'b0) pulse_hits++;
    end
    vectors++;
    if (pulse_hits !== 0) begin
      miscompares++;
      $display("FAIL idle_oval: %0d cycles with rsp_valid/ise_val set, expected 0", pulse_hits);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    stub_mode = 1;
    rsp_ready = 1'b0;
    issue(5'h01, 7'h40, 64'h1, 64'h2, 5'd3);
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'h12 || rsp_illegal !== 1'b0 ||
          rsp_rd !== 5'd3 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_hold: cycle %0d valid=%b data=%h illegal=%b rd=%0d req_ready=%b expected 1/12/0/3/0",
                 i, rsp_valid, rsp_data, rsp_illegal, rsp_rd, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_accept: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    end
    issue(5'h05, 7'h47, 64'h3, 64'h4, 5'd9);
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 2 || rsp_data !== 64'h34 || rsp_rd !== 5'd9 || rsp_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d data=%h rd=%0d illegal=%b expected 2/34/9/0",
               lat, rsp_data, rsp_rd, rsp_illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int hits;
    stub_mode = 0;
    issue(5'h03, 7'h00, 64'h77, 64'h88, 5'd2);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    force_oval = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || ise_val !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle: req_ready=%b ise_val=%b expected 0/1", req_ready, ise_val);
    end
    @(negedge clk);
    flush = 1'b0;
    force_oval = 1'b0;
    #1;
    vectors++;
    if (ise_val !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_after: ise_val=%b rsp_valid=%b req_ready=%b expected 0/0/1",
               ise_val, rsp_valid, req_ready);
    end
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) hits++;
    end
    vectors++;
    if (hits !== 0) begin
      miscompares++;
      $display("FAIL flush_no_rsp: rsp_valid seen %0d cycles, expected 0", hits);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    stub_mode = 0;
    issue(5'h1E, 7'h33, 64'hCAFE, 64'hBEEF, 5'd17);
    repeat (2) @(negedge clk);
    ise_rst = 1'b1;
    @(negedge clk);
    ise_rst = 1'b0;
    #1;
    vectors++;
    if ({ise_fn, ise_imm, ise_in1, ise_in2, ise_val, rsp_valid, rsp_data, rsp_rd, rsp_illegal} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: fn=%h imm=%h in1=%h val=%b rd=%0d expected all zero",
               ise_fn, ise_imm, ise_in1, ise_val, rsp_rd);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_idle: req_ready=%b expected 1", req_ready);
    end
    @(negedge clk);
    stub_mode = 1;
    issue(5'h09, 7'h5F, 64'h10, 64'h1, 5'd31);
    lat = 1;
    while (!rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 2 || rsp_data !== 64'h101 || rsp_rd !== 5'd31 || rsp_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_next_op: lat=%0d data=%h rd=%0d illegal=%b expected 2/101/31/0",
               lat, rsp_data, rsp_rd, rsp_illegal);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_comb_ise();
    test_timeout();
    test_multi_cycle();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xalu_ise_issue.md
Name: xalu_ise_issue

Overview:
- Core-side issuer for the custom-instruction ISE port; it is the requester end of the interface that the ISE dispatch unit answers.
- Accepts a decoded CUSTOM_x instruction from the execute stage and drives ise_fn/ise_imm/ise_in1/ise_in2/ise_val, holding them stable until the ISE answers.
- Waits for ise_oval, supporting both single-cycle and multi-cycle ISE units, then captures ise_out and returns it to writeback.
- If no unit claims the instruction within a bounded wait, it returns an illegal-instruction response.

Parameters:
- XLEN, 64, operand/result width.
- TIMEOUT, 8, maximum cycles ise_val is held without ise_oval before the op is declared illegal; must be >= 1.
- CW, $clog2(TIMEOUT+1), timeout counter width (derived, do not override).

Ports:
- ise_clk  in  1  clock
- ise_rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline kill; abandons any in-flight op
- req_valid  in  1  execute stage presents an ISE op
- req_ready  out  1  issuer can accept an op
- req_fn  in  5  custom opcode selector; [1:0] = CUSTOM_0..3
- req_imm  in  7  funct7 field
- req_rs1  in  XLEN  operand 1
- req_rs2  in  XLEN  operand 2
- req_rd  in  5  destination register index
- ise_fn  out  5  to ISE
- ise_imm  out  7  to ISE
- ise_in1  out  XLEN  to ISE
- ise_in2  out  XLEN  to ISE
- ise_val  out  1  op valid to ISE
- ise_oval  in  1  ISE claims op; result valid
- ise_out  in  XLEN  ISE result
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts result
- rsp_data  out  XLEN  result (0 when illegal)
- rsp_rd  out  5  destination index
- rsp_illegal  out  1  no ISE claimed the op

Behaviour:
- Clocking: single clock ise_clk. ise_rst is synchronous and active-high.
- Reset: state=IDLE; all registered outputs are 0: ise_fn, ise_imm, ise_in1, ise_in2, ise_val, rsp_valid, rsp_data, rsp_rd, rsp_illegal. Counter = 0.
- req_ready = (state==IDLE) & ~ise_rst & ~flush. It is combinational.
- IDLE: on req_valid & req_ready, latch fn/imm/rs1/rs2/rd into the ise_* and rd registers, set ise_val=1, counter=0, and go to ISSUE.
- ISSUE/WAIT: ise_val=1 and all ise_* outputs are held constant.
  - If ise_oval=1 this cycle: register rsp_data=ise_out and rsp_illegal=0, set rsp_valid=1 and ise_val=0 next cycle, and go to RESP.
  - Else if counter==TIMEOUT-1: set rsp_data=0, rsp_illegal=1, rsp_valid=1, ise_val=0, and go to RESP.
  - Else: counter+1 and go to (or stay in) WAIT.
  - ISSUE and WAIT differ only in that ISSUE is the first cycle; the same transition logic applies to both.
- RESP: rsp_valid stays high and rsp_data/rsp_rd/rsp_illegal stay stable until rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE. No new op is accepted in RESP.
- Latency:
  - Combinational ISE (oval in same cycle): accept at cycle N, ise_val at N+1, rsp_valid at N+2.
  - ISE answering k cycles after ise_val rises: rsp_valid at N+2+k.
  - Unclaimed op: rsp_valid with illegal at N+1+TIMEOUT.
  - Throughput: at most one op per 3 cycles.
- ise_oval is ignored whenever ise_val=0, so a late or spurious oval in IDLE or RESP is dropped.
- Flush has priority over every transition except reset. It applies in any state:
  - next state = IDLE;
  - ise_val=0 and rsp_valid=0 next cycle;
  - no response is produced;
  - an ise_oval arriving in the same cycle is discarded.
- Reset mid-operation behaves like flush and additionally clears all registers to their reset values.
- flush and req_valid in the same cycle: the op is not accepted, because req_ready=0.
- ise_out is captured only when ise_oval=1 and ise_val=1.

Decomposition:
- Shared package xalu_ise_pkg holds:
  - CUSTOM_0..CUSTOM_3 (2-bit);
  - the FSM state encoding IDLE/ISSUE/WAIT/RESP;
  - the ISE funct field widths (5, 7).
- No sub-module: the FSM, counter and operand registers form a single module.

Test Plan:
- Combinational ISE stub (oval=val when fn[1:0]=01, imm[6:5]=10); issue fn=5'h01, imm=7'h40, rs1=64'h1, rs2=64'h2, rd=5 → rsp_valid exactly 2 cycles after accept, rsp_data=stub result, rsp_rd=5, rsp_illegal=0.
- Unclaimed op fn=5'h00, imm=7'h00, TIMEOUT=8 → ise_val high for exactly 8 cycles, then rsp_valid with rsp_illegal=1 and rsp_data=0 at accept+9.
- Multi-cycle stub asserting oval 3 cycles after ise_val rises, with operands checked stable every cycle → rsp at accept+5; oval pulsed while idle afterwards → no response.
- rsp_ready held low for 4 cycles in RESP → rsp_valid, data and illegal held stable, req_ready=0 throughout; accepted on the 5th cycle, then back-to-back second op completes.
- flush asserted in WAIT cycle 2, with oval in the same cycle → no rsp_valid ever, ise_val=0 next cycle, req_ready=1 the following cycle.
- ise_rst asserted for 1 cycle mid-WAIT → all outputs 0 on the next edge, state IDLE; a subsequent op completes normally.
